regfile_wb_arbiter: RTL

//  Shares the register file's single write port (ioRD) between NUM_REQ write-back sources (ALU, LSU, CSR, ...).
//  - Round-robin arbitration over valid/ready requesters.
//  - Registered drive of ioRD_en/addr/data.
//  - Pending-write scoreboard so issue logic can detect RAW hazards on rs1/rs2.

---
 rtl/regfile_wb_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Shares the register file's single write port between NUM_REQ write-back
//   sources. It does three things:
//   - Round-robin arbitration over the requesters.
//   - Registered drive of the write port, with 1-cycle latency.
//   - A pending-write scoreboard that the issue logic uses to detect RAW
//     hazards on rs1/rs2.
//
// Ports
//   clock       rising-edge clock for all state
//   reset       asynchronous, active-low reset
//   req_valid   per-requester write pending
//   req_ready   per-requester grant this cycle (combinational)
//   req_addr    packed destination indices, slice i = [i*REG_NUM_WIDTH +: REG_NUM_WIDTH]
//   req_data    packed write data, slice i = [i*REG_WIDTH +: REG_WIDTH]
//   issue_en    an instruction with a destination register issued
//   issue_addr  destination index of that instruction
//   flush       drop all pending marks
//   rs1_addr    source index to check (rs2_addr likewise)
//   rs1_busy    rs1_addr has an outstanding write (rs2_busy likewise)
//   ioRD_en     register-file write enable
//   ioRD_addr   register-file write index
//   ioRD_data   register-file write data
module regfile_wb_arbiter #(
   parameter int NUM_REQ       = 3,
   parameter int REG_NUM_WIDTH = 5,
   parameter int REG_WIDTH     = 32
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*REG_NUM_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*REG_WIDTH-1:0]     req_data,
   input  logic                             issue_en,
   input  logic [REG_NUM_WIDTH-1:0]         issue_addr,
   input  logic                             flush,
   input  logic [REG_NUM_WIDTH-1:0]         rs1_addr,
   input  logic [REG_NUM_WIDTH-1:0]         rs2_addr,
   output logic                             rs1_busy,
   output logic                             rs2_busy,
   output logic                             ioRD_en,
   output logic [REG_NUM_WIDTH-1:0]         ioRD_addr,
   output logic [REG_WIDTH-1:0]             ioRD_data
);

   localparam int PTR_W   = $clog2(NUM_REQ);
   localparam int REG_CNT = 2 ** REG_NUM_WIDTH;

   logic [PTR_W-1:0]         ptr_r;
   logic [PTR_W-1:0]         grant_idx_s;
   logic [PTR_W-1:0]         ptr_nxt_s;
   logic [NUM_REQ-1:0]       grant_s;
   logic                     found_s;
   logic                     xfer_s;
   logic [REG_NUM_WIDTH-1:0] sel_addr_s;
   logic [REG_WIDTH-1:0]     sel_data_s;
   logic [REG_CNT-1:0]       pending_r;
   logic [REG_CNT-1:0]       pending_nxt_s;

   // Round-robin search: the first valid requester at or after ptr_r wins.
   always_comb begin
      logic [PTR_W-1:0] idx_v;
      grant_s     = '0;
      found_s     = 1'b0;
      grant_idx_s = '0;
      idx_v       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_v = PTR_W'((int'(ptr_r) + k) % NUM_REQ);
         if (!found_s && req_valid[idx_v]) begin
            found_s        = 1'b1;
            grant_s[idx_v] = 1'b1;
            grant_idx_s    = idx_v;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grants are suppressed while reset is asserted, so nothing transfers during reset.
   assign req_ready = grant_s & {NUM_REQ{reset}};
   assign xfer_s    = found_s & reset;
   assign ptr_nxt_s = (grant_idx_s == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + PTR_W'(1);

   // One-hot AND-OR mux of the granted requester's address and data.
   always_comb begin
      sel_addr_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_addr_s = sel_addr_s | (req_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH] & {REG_NUM_WIDTH{grant_s[i]}});
         sel_data_s = sel_data_s | (req_data[i*REG_WIDTH +: REG_WIDTH] & {REG_WIDTH{grant_s[i]}});
      end
   end

   // Scoreboard next state. The set term is ORed in after the clear term, so
   // an issue to the same index as a retiring write keeps the mark (the newer
   // producer wins). Flush overrides both. Bit 0 is never written.
   always_comb begin
      pending_nxt_s = '0;
      for (int i = 1; i < REG_CNT; i++) begin
         pending_nxt_s[i] = ~flush &
            ((issue_en & (issue_addr == REG_NUM_WIDTH'(i))) |
             (pending_r[i] & ~(xfer_s & (sel_addr_s == REG_NUM_WIDTH'(i)))));
      end
   end

   assign rs1_busy = pending_r[rs1_addr];
   assign rs2_busy = pending_r[rs2_addr];

   // Round-robin pointer and pending-write scoreboard state.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ptr_r     <= '0;
         pending_r <= '0;
      end else begin
         if (xfer_s) begin
            ptr_r <= ptr_nxt_s;
         end
         pending_r <= pending_nxt_s;
      end
   end

   // Registered write port. Writes to x0 still latch addr/data but never raise the enable.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ioRD_en   <= 1'b0;
         ioRD_addr <= '0;
         ioRD_data <= '0;
      end else begin
         ioRD_en <= xfer_s & (sel_addr_s != '0);
         if (xfer_s) begin
            ioRD_addr <= sel_addr_s;
            ioRD_data <= sel_data_s;
         end
      end
   end

endmodule
